// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// vend_pkg : shared types, coin values and price lookup for vend_controller
// Revision : 1.0
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_t;

    localparam int unsigned NICKEL_VAL       = 1;
    localparam int unsigned DIME_VAL         = 2;
    localparam int          DEFAULT_CREDIT_W = 4;

    function automatic int unsigned price_lookup(
        input logic [1:0]  idx,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        case (idx)
            2'd0:    price_lookup = p0;
            2'd1:    price_lookup = p1;
            2'd2:    price_lookup = p2;
            default: price_lookup = p3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_timeout.sv
`default_nettype none
// ============================================================================
// vend_timeout : idle counter for COLLECT; expire holds once TIMEOUT_CYCLES hit
// Revision     : 1.0
// ============================================================================
module vend_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// vend_controller : four-item vending sequencer (collect, dispense, change).
// Optional build macro VEND_TIMEOUT_EN adds auto-refund after idle COLLECT.
// Revision        : 1.0
// ============================================================================
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE0         = 5,
    parameter int PRICE1         = 4,
    parameter int PRICE2         = 6,
    parameter int PRICE3         = 3,
    parameter int CREDIT_W       = DEFAULT_CREDIT_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sel_valid,
    input  logic [1:0]          item_sel,
    input  logic                nickel_in,
    input  logic                dime_in,
    input  logic                cancel,
    output logic                dispense,
    output logic [1:0]          item_out,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);
    localparam logic [CREDIT_W:0] c_credit_max = {1'b0, {CREDIT_W{1'b1}}};

    vend_state_t         r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [1:0]          r_item;
    logic                r_dispense;
    logic [1:0]          r_item_out;
    logic                r_nickel_out;
    logic                r_coin_reject;
    logic                r_busy;

    vend_state_t         w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [1:0]          w_item_nxt;
    logic                w_reject_nxt;
    logic                w_accept;
    logic                w_coin_any;
    logic [CREDIT_W:0]   w_value;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_price;
    logic [CREDIT_W-1:0] w_after_vend;
    logic                w_expire;

    assign w_coin_any   = nickel_in | dime_in;
    // Nickel wins when both coins arrive together; the dime is bounced.
    assign w_value      = nickel_in ? (CREDIT_W+1)'(NICKEL_VAL) :
                          dime_in   ? (CREDIT_W+1)'(DIME_VAL)   : '0;
    assign w_sum        = {1'b0, r_credit} + w_value;
    assign w_price      = (CREDIT_W+1)'(price_lookup(r_item, PRICE0, PRICE1, PRICE2, PRICE3));
    assign w_after_vend = r_credit - w_price[CREDIT_W-1:0];

`ifdef VEND_TIMEOUT_EN
    vend_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_accept || (w_state_nxt != COLLECT)),
        .enable  (r_state == COLLECT),
        .expire  (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_item_nxt   = r_item;
        w_reject_nxt = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_reject_nxt = w_coin_any;
                if (sel_valid) begin
                    w_item_nxt  = item_sel;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel || w_expire) begin
                    w_reject_nxt = w_coin_any;
                    w_state_nxt  = (r_credit != '0) ? CHANGE : IDLE;
                end else if (w_coin_any) begin
                    w_reject_nxt = nickel_in & dime_in;
                    if (w_sum > c_credit_max) begin
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        if (w_sum >= w_price) begin
                            w_state_nxt = DISPENSE;
                        end
                    end
                end
            end
            DISPENSE: begin
                w_reject_nxt = w_coin_any;
                w_credit_nxt = w_after_vend;
                w_state_nxt  = (w_after_vend != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                w_reject_nxt = w_coin_any;
                if (r_credit <= CREDIT_W'(1)) begin
                    w_credit_nxt = '0;
                    w_state_nxt  = IDLE;
                end else begin
                    w_credit_nxt = r_credit - 1'b1;
                end
            end
            default: begin
                w_credit_nxt = '0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_credit      <= '0;
            r_item        <= 2'd0;
            r_dispense    <= 1'b0;
            r_item_out    <= 2'd0;
            r_nickel_out  <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_item        <= w_item_nxt;
            r_dispense    <= (w_state_nxt == DISPENSE);
            r_item_out    <= (w_state_nxt == DISPENSE) ? w_item_nxt : 2'd0;
            r_nickel_out  <= (w_state_nxt == CHANGE);
            r_coin_reject <= w_reject_nxt;
            r_busy        <= (w_state_nxt != IDLE);
        end
    end

    assign dispense    = r_dispense;
    assign item_out    = r_item_out;
    assign nickel_out  = r_nickel_out;
    assign coin_reject = r_coin_reject;
    assign busy        = r_busy;
    assign credit      = r_credit;

endmodule
`default_nettype wire
